// File: rtl/regfile_port_arbiter_if.sv
// Bundles both requesters' read/write handshakes and the register-bank side of the arbiter.
// The slave modport belongs to the arbiter; the master modport belongs to requesters and the bank.
interface regfile_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              a_rd_req;
  logic [ADDR_W-1:0] a_rd_addr1;
  logic [ADDR_W-1:0] a_rd_addr2;
  logic              a_rd_gnt;
  logic              a_rd_valid;
  logic [DATA_W-1:0] a_rd_data1;
  logic [DATA_W-1:0] a_rd_data2;

  logic              b_rd_req;
  logic [ADDR_W-1:0] b_rd_addr1;
  logic [ADDR_W-1:0] b_rd_addr2;
  logic              b_rd_gnt;
  logic              b_rd_valid;
  logic [DATA_W-1:0] b_rd_data1;
  logic [DATA_W-1:0] b_rd_data2;

  logic              a_wr_req;
  logic [ADDR_W-1:0] a_wr_addr;
  logic [DATA_W-1:0] a_wr_data;
  logic              a_wr_gnt;

  logic              b_wr_req;
  logic [ADDR_W-1:0] b_wr_addr;
  logic [DATA_W-1:0] b_wr_data;
  logic              b_wr_gnt;

  logic              rf_RegWrite;
  logic [ADDR_W-1:0] rf_read_reg1;
  logic [ADDR_W-1:0] rf_read_reg2;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;

  modport slave (
    input  a_rd_req, a_rd_addr1, a_rd_addr2,
    output a_rd_gnt, a_rd_valid, a_rd_data1, a_rd_data2,
    input  b_rd_req, b_rd_addr1, b_rd_addr2,
    output b_rd_gnt, b_rd_valid, b_rd_data1, b_rd_data2,
    input  a_wr_req, a_wr_addr, a_wr_data,
    output a_wr_gnt,
    input  b_wr_req, b_wr_addr, b_wr_data,
    output b_wr_gnt,
    output rf_RegWrite, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data,
    input  rf_data1, rf_data2
  );

  modport master (
    output a_rd_req, a_rd_addr1, a_rd_addr2,
    input  a_rd_gnt, a_rd_valid, a_rd_data1, a_rd_data2,
    output b_rd_req, b_rd_addr1, b_rd_addr2,
    input  b_rd_gnt, b_rd_valid, b_rd_data1, b_rd_data2,
    output a_wr_req, a_wr_addr, a_wr_data,
    input  a_wr_gnt,
    output b_wr_req, b_wr_addr, b_wr_data,
    input  b_wr_gnt,
    input  rf_RegWrite, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data,
    output rf_data1, rf_data2
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of a 2-read/1-write register bank between requesters A and B,
// with a one-stage read return pipeline and same-cycle write-to-read forwarding.
module regfile_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  regfile_port_arbiter_if.slave bus
);
  // Pointer value 0 prefers A, 1 prefers B.
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  logic              rd_win_b, wr_win_b, rd_gnt, wr_gnt;
  logic [ADDR_W-1:0] rd_reg1, rd_reg2, wr_reg;
  logic [DATA_W-1:0] wr_data, ret_data1, ret_data2;
  logic              a_valid, b_valid;

  always_comb begin
    rd_gnt   = !reset && (bus.a_rd_req || bus.b_rd_req);
    rd_win_b = !reset && bus.b_rd_req && (!bus.a_rd_req || rd_ptr_q);
    wr_gnt   = !reset && (bus.a_wr_req || bus.b_wr_req);
    wr_win_b = !reset && bus.b_wr_req && (!bus.a_wr_req || wr_ptr_q);

    rd_reg1 = rd_win_b ? bus.b_rd_addr1 : bus.a_rd_addr1;
    rd_reg2 = rd_win_b ? bus.b_rd_addr2 : bus.a_rd_addr2;
    wr_reg  = wr_win_b ? bus.b_wr_addr  : bus.a_wr_addr;
    wr_data = wr_win_b ? bus.b_wr_data  : bus.a_wr_data;

    rd_ptr_d   = rd_gnt ? !rd_win_b : rd_ptr_q;
    wr_ptr_d   = wr_gnt ? !wr_win_b : wr_ptr_q;
    rd_pend_d  = rd_gnt;
    rd_owner_d = rd_win_b;

    // The bank reads before the write lands, so capture the write for the reader.
    byp1_d     = rd_gnt && wr_gnt && (wr_reg == rd_reg1) && (rd_reg1 != '0);
    byp2_d     = rd_gnt && wr_gnt && (wr_reg == rd_reg2) && (rd_reg2 != '0);
    byp_data_d = (byp1_d || byp2_d) ? wr_data : byp_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign a_valid   = rd_pend_q && !rd_owner_q;
  assign b_valid   = rd_pend_q &&  rd_owner_q;
  assign ret_data1 = byp1_q ? byp_data_q : bus.rf_data1;
  assign ret_data2 = byp2_q ? byp_data_q : bus.rf_data2;

  assign bus.a_rd_gnt   = rd_gnt && !rd_win_b;
  assign bus.b_rd_gnt   = rd_win_b;
  assign bus.a_wr_gnt   = wr_gnt && !wr_win_b;
  assign bus.b_wr_gnt   = wr_win_b;

  assign bus.a_rd_valid = a_valid;
  assign bus.b_rd_valid = b_valid;
  assign bus.a_rd_data1 = a_valid ? ret_data1 : '0;
  assign bus.a_rd_data2 = a_valid ? ret_data2 : '0;
  assign bus.b_rd_data1 = b_valid ? ret_data1 : '0;
  assign bus.b_rd_data2 = b_valid ? ret_data2 : '0;

  assign bus.rf_RegWrite   = wr_gnt;
  assign bus.rf_read_reg1  = rd_reg1;
  assign bus.rf_read_reg2  = rd_reg2;
  assign bus.rf_write_reg  = wr_reg;
  assign bus.rf_write_data = wr_data;
endmodule
